fcl_bus_arbiter: RTL and testbench

Round-robin arbiter sharing the single FCL register bus (32-bit address/data, one-cycle read/write strobes, slave ack) among `NUM_MASTERS` requesters: the UART bus master plus future on-chip masters. It sits between the masters and the slave address decoder. It captures one outstanding single-cycle request per master, issues requests to the slave side one at a time, and returns the ack with read data, or a timeout error, to the owning master.

---
 rtl/fcl_bus_pkg.sv | 20 ++
 rtl/fcl_rr_pick.sv | 30 +++
 rtl/fcl_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_fcl_bus_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcl_bus_pkg.sv
// Shared FCL bus constants, arbiter FSM states and the clogb2 sizing helper.
package fcl_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    WAIT = 1'b1
  } fcl_state_e;

  // Index width for `value` items; never returns less than 1.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fcl_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module fcl_rr_pick
  import fcl_bus_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = clogb2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic            valid,
  output logic [IdxW-1:0] idx
);

  logic [IdxW:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < int'(N); k++) begin
      cand = {1'b0, ptr} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(N)) cand = cand - (IdxW+1)'(N);
      if (!valid && req[cand[IdxW-1:0]]) begin
        valid = 1'b1;
        idx   = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/fcl_bus_arbiter.sv
// Round-robin arbiter sharing the FCL register bus among NUM_MASTERS requesters,
// one outstanding single-cycle request per master, guarded by a per-transaction watchdog.
module fcl_bus_arbiter
  import fcl_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS  = 4,
  parameter int unsigned BUS_TIME_OUT = 100
) (
  input  logic                            sys_clk,
  input  logic                            _reset,
  input  logic [NUM_MASTERS-1:0]          m_read,
  input  logic [NUM_MASTERS-1:0]          m_write,
  input  logic [ADDR_W*NUM_MASTERS-1:0]   m_addr,
  input  logic [DATA_W*NUM_MASTERS-1:0]   m_wdata,
  output logic [NUM_MASTERS-1:0]          m_ack,
  output logic [NUM_MASTERS-1:0]          m_error,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic                            s_read,
  output logic                            s_write,
  input  logic                            s_ack,
  input  logic [DATA_W-1:0]               s_rdata,
  output logic [clogb2(NUM_MASTERS)-1:0]  grant_id,
  output logic                            busy,
  output logic [7:0]                      timeout_count
);

  localparam int unsigned     IdxW    = clogb2(NUM_MASTERS);
  localparam int unsigned     WdW     = clogb2(BUS_TIME_OUT);
  localparam logic [WdW-1:0]  WdLast  = WdW'(BUS_TIME_OUT - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_MASTERS - 1);

  fcl_state_e             state;
  logic [NUM_MASTERS-1:0] pending;
  logic [NUM_MASTERS-1:0] pend_wr;
  logic [NUM_MASTERS-1:0] accept;
  logic [NUM_MASTERS-1:0] clr;
  logic [IdxW-1:0]        rr_ptr;
  logic [IdxW-1:0]        pick_idx;
  logic                   pick_valid;
  logic [WdW-1:0]         wd;
  logic [ADDR_W-1:0]      addr_buf  [NUM_MASTERS];
  logic [DATA_W-1:0]      wdata_buf [NUM_MASTERS];

  // Slot of the granted master is released on ack or on watchdog expiry.
  always_comb begin
    clr = '0;
    if (state == WAIT && (s_ack || wd == WdLast)) clr[grant_id] = 1'b1;
  end

  // A strobe on a busy slot is dropped, unless that slot is being released this cycle.
  assign accept = (m_read | m_write) & (~pending | clr);

  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (accept[i]) begin
        addr_buf[i]  <= m_addr[ADDR_W*i +: ADDR_W];
        wdata_buf[i] <= m_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  fcl_rr_pick #(
    .N    (NUM_MASTERS),
    .IdxW (IdxW)
  ) u_pick (
    .req   (pending),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge sys_clk or negedge _reset) begin
    if (!_reset) begin
      state         <= ARB;
      pending       <= '0;
      pend_wr       <= '0;
      rr_ptr        <= '0;
      wd            <= '0;
      grant_id      <= '0;
      s_addr        <= '0;
      s_wdata       <= '0;
      s_read        <= 1'b0;
      s_write       <= 1'b0;
      m_ack         <= '0;
      m_error       <= '0;
      m_rdata       <= '0;
      busy          <= 1'b0;
      timeout_count <= '0;
    end else begin
      s_read  <= 1'b0;
      s_write <= 1'b0;
      m_ack   <= '0;
      m_error <= '0;
      pending <= (pending & ~clr) | accept;
      pend_wr <= (pend_wr & ~accept) | (m_write & accept);
      unique case (state)
        ARB: begin
          if (pick_valid) begin
            grant_id <= pick_idx;
            s_addr   <= addr_buf[pick_idx];
            s_wdata  <= wdata_buf[pick_idx];
            s_write  <= pend_wr[pick_idx];
            s_read   <= ~pend_wr[pick_idx];
            rr_ptr   <= (pick_idx == LastIdx) ? '0 : pick_idx + 1'b1;
            wd       <= '0;
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          wd <= wd + 1'b1;
          if (s_ack) begin
            m_rdata         <= s_rdata;
            m_ack[grant_id] <= 1'b1;
            busy            <= 1'b0;
            state           <= ARB;
          end else if (wd == WdLast) begin
            m_error[grant_id] <= 1'b1;
            if (timeout_count != 8'hFF) timeout_count <= timeout_count + 1'b1;
            busy  <= 1'b0;
            state <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_fcl_bus_arbiter.sv
// Scoreboard bench for fcl_bus_arbiter: directed stimulus queues expected slave issues and
// master completions; independent monitors pop and compare when the DUT presents them.
`timescale 1ns/1ps
module tb_fcl_bus_arbiter;
  import fcl_bus_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 8;

  logic           sys_clk = 1'b0;
  logic           _reset;
  logic [N-1:0]   m_read, m_write;
  logic [32*N-1:0] m_addr, m_wdata;
  logic [N-1:0]   m_ack, m_error;
  logic [31:0]    m_rdata, s_addr, s_wdata;
  logic [31:0]    s_rdata = '0;
  logic           s_read, s_write;
  logic           s_ack = 1'b0;
  logic [1:0]     grant_id;
  logic           busy;
  logic [7:0]     timeout_count;

  fcl_bus_arbiter #(
    .NUM_MASTERS  (N),
    .BUS_TIME_OUT (TO)
  ) dut (
    .sys_clk       (sys_clk),
    ._reset        (_reset),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_addr        (m_addr),
    .m_wdata       (m_wdata),
    .m_ack         (m_ack),
    .m_error       (m_error),
    .m_rdata       (m_rdata),
    .s_addr        (s_addr),
    .s_wdata       (s_wdata),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_ack         (s_ack),
    .s_rdata       (s_rdata),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_count (timeout_count)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  gid;
  } iss_t;

  typedef struct {
    int          cyc;
    logic [N-1:0] ack;
    logic [N-1:0] err;
    logic [31:0] rdata;
    logic [7:0]  tcnt;
  } cpl_t;

  iss_t iss_q[$];
  cpl_t cpl_q[$];
  int   checks = 0;
  int   errors = 0;

  // Slave behaviour: ack `slave_delay` cycles after the strobe cycle; negative means never.
  int          slave_delay = 1;
  logic [31:0] slave_rdata = '0;
  int          stray_cnt   = 0;
  int          stray_done  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void exp_iss(input int c, input logic wr, input logic [31:0] a,
                                  input logic [31:0] d, input logic [1:0] g);
    iss_t e;
    e.cyc = c; e.wr = wr; e.addr = a; e.wdata = d; e.gid = g;
    iss_q.push_back(e);
  endfunction

  function automatic void exp_cpl(input int c, input logic [N-1:0] ack, input logic [N-1:0] err,
                                  input logic [31:0] rd, input logic [7:0] t);
    cpl_t e;
    e.cyc = c; e.ack = ack; e.err = err; e.rdata = rd; e.tcnt = t;
    cpl_q.push_back(e);
  endfunction

  function automatic logic [32*N-1:0] fl(input logic [31:0] v0, input logic [31:0] v1,
                                         input logic [31:0] v2, input logic [31:0] v3);
    return {v3, v2, v1, v0};
  endfunction

  always @(negedge sys_clk) begin : issue_mon
    iss_t e;
    if (_reset && (s_read || s_write)) begin
      if (iss_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL issue_unexpected at cycle %0d: got addr %h grant %0d, expected none",
                 cyc, s_addr, grant_id);
      end else begin
        e = iss_q.pop_front();
        check("issue_cycle", 64'(cyc), 64'(e.cyc));
        check("issue_rw", 64'({s_write, s_read}), 64'({e.wr, ~e.wr}));
        check("issue_addr", 64'(s_addr), 64'(e.addr));
        check("issue_grant", 64'(grant_id), 64'(e.gid));
        check("issue_busy", 64'(busy), 64'(1));
        if (e.wr) check("issue_wdata", 64'(s_wdata), 64'(e.wdata));
      end
    end
  end

  always @(negedge sys_clk) begin : cpl_mon
    cpl_t e;
    if (_reset && (m_ack != '0 || m_error != '0)) begin
      if (cpl_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL cpl_unexpected at cycle %0d: got ack %b error %b, expected none",
                 cyc, m_ack, m_error);
      end else begin
        e = cpl_q.pop_front();
        check("cpl_cycle", 64'(cyc), 64'(e.cyc));
        check("cpl_ack", 64'(m_ack), 64'(e.ack));
        check("cpl_error", 64'(m_error), 64'(e.err));
        check("cpl_tcount", 64'(timeout_count), 64'(e.tcnt));
        if (e.ack != '0) check("cpl_rdata", 64'(m_rdata), 64'(e.rdata));
      end
    end
  end

  always @(negedge sys_clk) begin : slave
    int d;
    if (_reset && (s_read || s_write) && slave_delay >= 0) begin
      d = slave_delay;
      if (d > 0) begin
        repeat (d) @(posedge sys_clk);
        #1;
      end
      s_ack   = 1'b1;
      s_rdata = slave_rdata;
      @(posedge sys_clk); #1;
      s_ack   = 1'b0;
    end else if (stray_cnt != stray_done) begin
      stray_done = stray_cnt;
      s_ack      = 1'b1;
      s_rdata    = 32'hBAD0_BAD0;
      @(posedge sys_clk); #1;
      s_ack      = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Drive a one-cycle strobe starting in the current cycle.
  task automatic strobe(input logic [N-1:0] rd, input logic [N-1:0] wr,
                        input logic [32*N-1:0] a, input logic [32*N-1:0] d);
    m_read = rd; m_write = wr; m_addr = a; m_wdata = d;
    tick(1);
    m_read = '0; m_write = '0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((iss_q.size() != 0 || cpl_q.size() != 0 || busy) && n < budget) begin
      tick(1);
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d issues and %0d completions outstanding, expected 0",
               iss_q.size(), cpl_q.size());
      iss_q.delete();
      cpl_q.delete();
    end
    tick(2);
  endtask

  task automatic do_reset();
    _reset = 1'b0;
    tick(2);
    _reset = 1'b1;
    tick(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_ack"}, 64'(m_ack), 64'(0));
    check({tag, "_m_error"}, 64'(m_error), 64'(0));
    check({tag, "_m_rdata"}, 64'(m_rdata), 64'(0));
    check({tag, "_s_addr"}, 64'(s_addr), 64'(0));
    check({tag, "_s_wdata"}, 64'(s_wdata), 64'(0));
    check({tag, "_s_strobes"}, 64'({s_read, s_write}), 64'(0));
    check({tag, "_grant_id"}, 64'(grant_id), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_tcount"}, 64'(timeout_count), 64'(0));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL global_timeout: got no finish by %0t, expected finish", $time);
    $fatal(1, "bench timed out");
  end

  initial begin : main
    int c;
    m_read = '0; m_write = '0; m_addr = '0; m_wdata = '0;
    _reset = 1'b0;
    tick(2);
    check_all_zero("reset");
    _reset = 1'b1;
    tick(1);

    // Single read from master 1, slave acks the cycle after the strobe.
    slave_delay = 1; slave_rdata = 32'hDEAD_BEEF;
    c = cyc;
    exp_iss(c + 2, 1'b0, 32'h0000_1000, 32'h0, 2'd1);
    exp_cpl(c + 4, 4'b0010, 4'b0000, 32'hDEAD_BEEF, 8'd0);
    strobe(4'b0010, 4'b0000, fl(0, 32'h0000_1000, 0, 0), '0);
    drain(40);

    // Three simultaneous writes from rr_ptr=0: 0 -> 2 -> 3, three cycles apart.
    do_reset();
    slave_rdata = 32'h1111_1111;
    c = cyc;
    exp_iss(c + 2, 1'b1, 32'h100, 32'h10, 2'd0);
    exp_iss(c + 5, 1'b1, 32'h200, 32'h20, 2'd2);
    exp_iss(c + 8, 1'b1, 32'h300, 32'h30, 2'd3);
    exp_cpl(c + 4,  4'b0001, 4'b0000, 32'h1111_1111, 8'd0);
    exp_cpl(c + 7,  4'b0100, 4'b0000, 32'h1111_1111, 8'd0);
    exp_cpl(c + 10, 4'b1000, 4'b0000, 32'h1111_1111, 8'd0);
    strobe(4'b0000, 4'b1101, fl(32'h100, 0, 32'h200, 32'h300), fl(32'h10, 0, 32'h20, 32'h30));
    drain(60);

    // Serve master 2 alone, then 0 and 3 together: 3 goes first.
    c = cyc;
    exp_iss(c + 2, 1'b0, 32'h2000, 32'h0, 2'd2);
    exp_cpl(c + 4, 4'b0100, 4'b0000, 32'h1111_1111, 8'd0);
    strobe(4'b0100, 4'b0000, fl(0, 0, 32'h2000, 0), '0);
    drain(40);
    c = cyc;
    exp_iss(c + 2, 1'b0, 32'h3A0, 32'h0, 2'd3);
    exp_iss(c + 5, 1'b0, 32'h0A0, 32'h0, 2'd0);
    exp_cpl(c + 4, 4'b1000, 4'b0000, 32'h1111_1111, 8'd0);
    exp_cpl(c + 7, 4'b0001, 4'b0000, 32'h1111_1111, 8'd0);
    strobe(4'b1001, 4'b0000, fl(32'h0A0, 0, 0, 32'h3A0), '0);
    drain(40);

    // Timeout on master 1, with master 2 queued behind it.
    do_reset();
    slave_delay = -1; slave_rdata = 32'h2222_2222;
    c = cyc;
    exp_iss(c + 2,  1'b0, 32'h1100, 32'h0, 2'd1);
    exp_cpl(c + 10, 4'b0000, 4'b0010, 32'h0, 8'd1);
    exp_iss(c + 11, 1'b0, 32'h2200, 32'h0, 2'd2);
    exp_cpl(c + 13, 4'b0100, 4'b0000, 32'h2222_2222, 8'd1);
    strobe(4'b0010, 4'b0000, fl(0, 32'h1100, 0, 0), '0);
    tick(2);
    slave_delay = 1;
    strobe(4'b0100, 4'b0000, fl(0, 0, 32'h2200, 0), '0);
    drain(60);

    // Ack lands in the last watchdog cycle: ack wins, count unchanged.
    slave_delay = int'(TO) - 1; slave_rdata = 32'h3333_3333;
    c = cyc;
    exp_iss(c + 2, 1'b0, 32'h0400, 32'h0, 2'd0);
    exp_cpl(c + 2 + int'(TO), 4'b0001, 4'b0000, 32'h3333_3333, 8'd1);
    strobe(4'b0001, 4'b0000, fl(32'h0400, 0, 0, 0), '0);
    drain(60);

    // Read and write together: write wins; slave acks in the strobe cycle.
    slave_delay = 0; slave_rdata = 32'h4444_4444;
    c = cyc;
    exp_iss(c + 2, 1'b1, 32'h40, 32'hCAFE_F00D, 2'd0);
    exp_cpl(c + 3, 4'b0001, 4'b0000, 32'h4444_4444, 8'd1);
    strobe(4'b0001, 4'b0001, fl(32'h40, 0, 0, 0), fl(32'hCAFE_F00D, 0, 0, 0));
    drain(40);

    // A slave ack while idle must produce nothing.
    stray_cnt++;
    tick(5);
    check("stray_ack_tcount", 64'(timeout_count), 64'(1));
    check("stray_ack_rdata", 64'(m_rdata), 64'(32'h4444_4444));

    // Reset mid-WAIT with masters 1 and 2 pending.
    slave_delay = -1;
    c = cyc;
    exp_iss(c + 2, 1'b0, 32'h1500, 32'h0, 2'd1);
    strobe(4'b0110, 4'b0000, fl(0, 32'h1500, 32'h2500, 0), '0);
    tick(3);
    check("pre_reset_busy", 64'(busy), 64'(1));
    _reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick(2);
    _reset = 1'b1;
    tick(15);
    // rr_ptr must be back at 0, so master 1 precedes master 3.
    slave_delay = 1; slave_rdata = 32'h5555_5555;
    c = cyc;
    exp_iss(c + 2, 1'b0, 32'h1700, 32'h0, 2'd1);
    exp_iss(c + 5, 1'b0, 32'h3700, 32'h0, 2'd3);
    exp_cpl(c + 4, 4'b0010, 4'b0000, 32'h5555_5555, 8'd0);
    exp_cpl(c + 7, 4'b1000, 4'b0000, 32'h5555_5555, 8'd0);
    strobe(4'b1010, 4'b0000, fl(0, 32'h1700, 0, 32'h3700), '0);
    drain(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
